// File: rtl/param_ram.sv
// DEPTH x WIDTH scratch RAM: one synchronous write port and two registered read ports.
// Reset starts a hardware clear sequence that writes CLEAR_VAL into every word, one per cycle.
module param_ram #(
  parameter int unsigned      WIDTH     = 2,
  parameter int unsigned      DEPTH     = 4,
  parameter int unsigned      ADDR_W    = 2,
  parameter bit               BYPASS    = 1'b1,
  parameter logic [WIDTH-1:0] CLEAR_VAL = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en0,
  input  logic [ADDR_W-1:0] rd_addr0,
  output logic [WIDTH-1:0]  rd_data0,
  output logic              rd_valid0,
  input  logic              rd_en1,
  input  logic [ADDR_W-1:0] rd_addr1,
  output logic [WIDTH-1:0]  rd_data1,
  output logic              rd_valid1,
  output logic              busy,
  output logic              err
);

  localparam logic [ADDR_W:0]   DEPTH_W  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_clr_ptr;
  logic [ADDR_W-1:0] w_clr_ptr_next;
  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [WIDTH-1:0]  r_rd_data0;
  logic [WIDTH-1:0]  r_rd_data1;
  logic              r_rd_valid0;
  logic              r_rd_valid1;
  logic              r_err;

  logic              w_ready;
  logic              w_clr_we;
  logic              w_wr_in;
  logic              w_rd0_in;
  logic              w_rd1_in;
  logic              w_wr_ok;
  logic              w_bad_access;
  logic [WIDTH-1:0]  w_rd_word0;
  logic [WIDTH-1:0]  w_rd_word1;

  function automatic logic f_in_range(input logic [ADDR_W-1:0] addr);
    return ({1'b0, addr} < DEPTH_W);
  endfunction

  always_ff @(posedge clock) begin
    r_state   <= w_state_next;
    r_clr_ptr <= w_clr_ptr_next;
  end

  always_comb begin
    w_state_next   = r_state;
    w_clr_ptr_next = r_clr_ptr;
    if (reset) begin
      w_state_next   = ST_CLEAR;
      w_clr_ptr_next = '0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          if (r_clr_ptr == LAST_PTR) w_state_next = ST_READY;
          else                       w_clr_ptr_next = r_clr_ptr + 1'b1;
        end
        ST_READY: w_state_next = ST_READY;
        default:  w_state_next = ST_CLEAR;
      endcase
    end
  end

  always_comb begin
    w_ready      = (r_state == ST_READY) && !reset;
    w_clr_we     = (r_state == ST_CLEAR) && !reset;
    w_wr_in      = f_in_range(wr_addr);
    w_rd0_in     = f_in_range(rd_addr0);
    w_rd1_in     = f_in_range(rd_addr1);
    w_wr_ok      = w_ready && wr_en && w_wr_in;
    w_bad_access = w_ready && ((wr_en && !w_wr_in) ||
                               (rd_en0 && !w_rd0_in) ||
                               (rd_en1 && !w_rd1_in));
  end

  // Collision handling: write-first forwards wr_data, read-first falls through to the old word.
  always_comb begin
    w_rd_word0 = '0;
    if (w_rd0_in) begin
      if (BYPASS && wr_en && w_wr_in && (wr_addr == rd_addr0)) w_rd_word0 = wr_data;
      else                                                    w_rd_word0 = r_mem[rd_addr0];
    end
  end

  always_comb begin
    w_rd_word1 = '0;
    if (w_rd1_in) begin
      if (BYPASS && wr_en && w_wr_in && (wr_addr == rd_addr1)) w_rd_word1 = wr_data;
      else                                                    w_rd_word1 = r_mem[rd_addr1];
    end
  end

  // Array has no reset of its own; the clear sequence is the only initialisation.
  always_ff @(posedge clock) begin
    if (w_clr_we)     r_mem[r_clr_ptr] <= CLEAR_VAL;
    else if (w_wr_ok) r_mem[wr_addr]   <= wr_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rd_data0  <= '0;
      r_rd_data1  <= '0;
      r_rd_valid0 <= 1'b0;
      r_rd_valid1 <= 1'b0;
      r_err       <= 1'b0;
    end else if (w_ready) begin
      r_rd_valid0 <= rd_en0;
      r_rd_valid1 <= rd_en1;
      if (rd_en0) r_rd_data0 <= w_rd_word0;
      if (rd_en1) r_rd_data1 <= w_rd_word1;
      if (w_bad_access) r_err <= 1'b1;
    end else begin
      r_rd_valid0 <= 1'b0;
      r_rd_valid1 <= 1'b0;
    end
  end

  assign busy      = (r_state == ST_CLEAR);
  assign err       = r_err;
  assign rd_data0  = r_rd_data0;
  assign rd_data1  = r_rd_data1;
  assign rd_valid0 = r_rd_valid0;
  assign rd_valid1 = r_rd_valid1;

endmodule
